// File: rtl/groestl_pkg.sv
// Groestl-256 message buffer shared constants.
// Holds block geometry and the word-to-slot mapping.
package groestl_pkg;

  localparam int WORD_W        = 16;
  localparam int BLK_W         = 512;
  localparam int WORDS_PER_BLK = BLK_W / WORD_W;
  localparam int WCNT_W        = 5;

  // MSB index of word slot idx; word 0 sits at the top of the block
  function automatic int slot_hi(
    input int idx,
    input int ww,
    input int bw
  );
    return bw - 1 - ww * idx;
  endfunction

endpackage

// File: rtl/groestl_msg_buffer.sv
// Groestl-256 message buffer: packs host words into blocks
// and hands them to the core through a one-deep output register.
module groestl_msg_buffer #(
  parameter int WORD_W = groestl_pkg::WORD_W,
  parameter int BLK_W  = groestl_pkg::BLK_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              ld_msg,
  input  logic [WORD_W-1:0] idata,
  input  logic              last_in,
  output logic              m_valid,
  output logic [BLK_W-1:0]  m_data,
  output logic              m_last,
  input  logic              m_ready,
  output logic [63:0]       blk_cnt,
  output logic              ovf
);

  localparam int NW = BLK_W / WORD_W;
  localparam int CW = $clog2(NW);

  logic [BLK_W-1:0] abuf;
  logic [CW-1:0]    wcnt;
  logic             afull;
  logic             last_r;
  logic             xfer;
  logic             acc;
  logic             wlast;

  // Move a full block out whenever the output slot is free or draining
  assign xfer  = afull && (!m_valid || m_ready);
  assign acc   = ld_msg && (!afull || xfer);
  assign wlast = (wcnt == CW'(NW - 1));

  // Assembly buffer, word counter and full flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      abuf   <= '0;
      wcnt   <= '0;
      afull  <= 1'b0;
      last_r <= 1'b0;
    end else if (clr) begin
      wcnt   <= '0;
      afull  <= 1'b0;
      last_r <= 1'b0;
    end else begin
      if (xfer)
        afull <= 1'b0;
      if (acc) begin
        abuf[groestl_pkg::slot_hi(int'(wcnt), WORD_W, BLK_W) -: WORD_W]
          <= idata;
        if (wlast) begin
          wcnt   <= '0;
          afull  <= 1'b1;
          last_r <= last_in;
        end else begin
          wcnt <= wcnt + CW'(1);
        end
      end
    end
  end

  // Output register toward the core
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_last  <= 1'b0;
    end else if (clr) begin
      m_valid <= 1'b0;
      m_last  <= 1'b0;
    end else if (xfer) begin
      m_valid <= 1'b1;
      m_data  <= abuf;
      m_last  <= last_r;
    end else if (m_valid && m_ready) begin
      m_valid <= 1'b0;
    end
  end

  // Block counter for length padding and sticky overflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blk_cnt <= '0;
      ovf     <= 1'b0;
    end else if (clr) begin
      blk_cnt <= '0;
      ovf     <= 1'b0;
    end else begin
      if (xfer)
        blk_cnt <= blk_cnt + 64'd1;
      if (ld_msg && afull && !xfer)
        ovf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_groestl_msg_buffer.sv
// Bench for groestl_msg_buffer: queued expected blocks
// checked by a monitor at each core handshake.
module tb_groestl_msg_buffer;

  typedef struct {
    logic [511:0] data;
    logic         last;
    logic [63:0]  cnt;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic         clr;
  logic         ld_msg;
  logic [15:0]  idata;
  logic         last_in;
  logic         m_valid;
  logic [511:0] m_data;
  logic         m_last;
  logic         m_ready;
  logic [63:0]  blk_cnt;
  logic         ovf;

  exp_t sb[$];
  int   checks;
  int   failures;
  logic [63:0] exp_cnt;

  groestl_msg_buffer dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (clr),
    .ld_msg  (ld_msg),
    .idata   (idata),
    .last_in (last_in),
    .m_valid (m_valid),
    .m_data  (m_data),
    .m_last  (m_last),
    .m_ready (m_ready),
    .blk_cnt (blk_cnt),
    .ovf     (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: compare every accepted block against the queue head
  always @(negedge clk) begin
    if (rst_n && !clr && m_valid && m_ready) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL blk_unexpected: got cnt %0d expected none",
                 blk_cnt);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (m_data !== e.data || m_last !== e.last ||
            blk_cnt !== e.cnt) begin
          failures++;
          $display("FAIL blk_data: got w0=%h w31=%h last=%b cnt=%0d expected w0=%h w31=%h last=%b cnt=%0d",
                   m_data[511:496], m_data[15:0], m_last, blk_cnt,
                   e.data[511:496], e.data[15:0], e.last, e.cnt);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [15:0] w, input logic l);
    ld_msg  = 1'b1;
    idata   = w;
    last_in = l;
    tick();
    ld_msg  = 1'b0;
    last_in = 1'b0;
  endtask

  task automatic send_block(input logic [15:0] w0,
                            input logic [15:0] base,
                            input logic l);
    exp_t e;
    logic [15:0] w;
    e.data = '0;
    for (int i = 0; i < 32; i++) begin
      w = (i == 0) ? w0 : base + 16'(i);
      e.data[511 - 16*i -: 16] = w;
    end
    exp_cnt++;
    e.last = l;
    e.cnt  = exp_cnt;
    sb.push_back(e);
    for (int i = 0; i < 32; i++) begin
      w = (i == 0) ? w0 : base + 16'(i);
      send_word(w, (i == 31) ? l : 1'b0);
    end
  endtask

  task automatic wait_empty(input string nm);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL %s: got %0d pending blocks expected 0",
               nm, sb.size());
      sb.delete();
    end
    repeat (2) tick();
  endtask

  task automatic do_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    sb.delete();
    exp_cnt = 0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    exp_cnt  = 0;
    rst_n    = 1'b0;
    clr      = 1'b0;
    ld_msg   = 1'b0;
    idata    = '0;
    last_in  = 1'b0;
    m_ready  = 1'b0;
    repeat (2) tick();

    chk("rst_m_valid", 64'(m_valid), 64'd0);
    chk("rst_m_data",  64'(m_data[511:448] | m_data[63:0]), 64'd0);
    chk("rst_m_last",  64'(m_last), 64'd0);
    chk("rst_blk_cnt", blk_cnt, 64'd0);
    chk("rst_ovf",     64'(ovf), 64'd0);
    rst_n = 1'b1;
    tick();

    // Single block with latency check
    m_ready = 1'b1;
    send_block(16'h0000, 16'h0000, 1'b0);
    @(negedge clk);
    chk("lat_t1_valid", 64'(m_valid), 64'd0);
    @(negedge clk);
    chk("lat_t2_valid", 64'(m_valid), 64'd1);
    chk("lat_t2_cnt", blk_cnt, 64'd1);
    @(negedge clk);
    chk("one_cycle_valid", 64'(m_valid), 64'd0);
    wait_empty("blk0_drain");

    // Final-block flag follows its block
    send_block(16'h0100, 16'h0100, 1'b1);
    send_block(16'h0200, 16'h0200, 1'b0);
    wait_empty("last_drain");

    // Backpressure, overflow and ordered release
    do_clr();
    chk("clr_cnt", blk_cnt, 64'd0);
    m_ready = 1'b0;
    send_block(16'h0300, 16'h0300, 1'b0);
    send_block(16'h0400, 16'h0400, 1'b1);
    chk("ovf_before", 64'(ovf), 64'd0);
    send_word(16'hBEEF, 1'b0);
    repeat (3) tick();
    chk("ovf_set", 64'(ovf), 64'd1);
    chk("hold_valid", 64'(m_valid), 64'd1);
    chk("hold_w0", 64'(m_data[511:496]), 64'h0300);
    chk("hold_w31", 64'(m_data[15:0]), 64'h031F);
    chk("hold_cnt", blk_cnt, 64'd1);
    m_ready = 1'b1;
    wait_empty("bp_drain");
    chk("bp_cnt", blk_cnt, 64'd2);
    chk("ovf_sticky", 64'(ovf), 64'd1);

    // Word accepted in the same cycle as the transfer
    do_clr();
    m_ready = 1'b0;
    send_block(16'h0500, 16'h0500, 1'b0);
    send_block(16'h0600, 16'h0600, 1'b0);
    m_ready = 1'b1;
    send_block(16'hA5A5, 16'h0700, 1'b0);
    wait_empty("same_cycle_drain");
    chk("same_cycle_ovf", 64'(ovf), 64'd0);
    chk("same_cycle_cnt", blk_cnt, 64'd3);

    // Reset mid-block
    for (int i = 0; i < 10; i++)
      send_word(16'hDEAD, 1'b0);
    rst_n = 1'b0;
    #3;
    sb.delete();
    exp_cnt = 0;
    chk("mid_rst_valid", 64'(m_valid), 64'd0);
    chk("mid_rst_data", 64'(m_data[511:448]), 64'd0);
    chk("mid_rst_cnt", blk_cnt, 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    send_block(16'h0800, 16'h0800, 1'b0);
    wait_empty("post_rst_drain");
    chk("post_rst_cnt", blk_cnt, 64'd1);

    // Clear overrides word, transfer and handshake
    m_ready = 1'b0;
    send_block(16'h0900, 16'h0900, 1'b1);
    send_block(16'h0A00, 16'h0A00, 1'b0);
    send_word(16'hCAFE, 1'b0);
    tick();
    chk("pre_clr_ovf", 64'(ovf), 64'd1);
    m_ready = 1'b1;
    ld_msg  = 1'b1;
    idata   = 16'h1234;
    do_clr();
    ld_msg  = 1'b0;
    chk("clr_valid", 64'(m_valid), 64'd0);
    chk("clr_m_last", 64'(m_last), 64'd0);
    chk("clr_blk_cnt", blk_cnt, 64'd0);
    chk("clr_ovf", 64'(ovf), 64'd0);
    tick();
    chk("clr_no_xfer", 64'(m_valid), 64'd0);
    send_block(16'h0B00, 16'h0B00, 1'b0);
    wait_empty("post_clr_drain");
    chk("post_clr_cnt", blk_cnt, 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/groestl_msg_buffer.md
GROESTL_MSG_BUFFER -- requirements
Module: groestl_msg_buffer

Interface
REQ-001 Parameter WORD_W, default 16, width of one input message word.
REQ-002 Parameter BLK_W, default 512, width of one Groestl-256 message block; BLK_W/WORD_W (32) words per block.
REQ-003 clk  input  1  clock, all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 clr  input  1  synchronous clear at start of a new message.
REQ-006 ld_msg  input  1  word strobe from the host-side interface; one word per high cycle.
REQ-007 idata  input  WORD_W  message word qualified by ld_msg.
REQ-008 last_in  input  1  marks the block containing this word as final; sampled only with word 31.
REQ-009 m_valid  output  1  assembled block available to core.
REQ-010 m_data  output  BLK_W  assembled block, word 0 in bits [511:496].
REQ-011 m_last  output  1  final-block flag accompanying m_data.
REQ-012 m_ready  input  1  core accepts block when high with m_valid.
REQ-013 blk_cnt  output  64  number of blocks handed off since clear, for length padding.
REQ-014 ovf  output  1  sticky: word dropped because assembly buffer was full.

Function
REQ-015 Two storage stages: assembly buffer (abuf, word counter wcnt 0..31, flag afull) and output register (m_data/m_valid/m_last).
REQ-016 Accept = ld_msg && (!afull || xfer); accepted word written to slot wcnt, bits [BLK_W-1-WORD_W*wcnt -: WORD_W].
REQ-017 Accepted word at wcnt=31: afull set next cycle, last_in captured into last_r, wcnt wraps to 0.
REQ-018 ld_msg while afull && !xfer: word discarded, abuf/wcnt unchanged, ovf set and held until clr or reset.
REQ-019 xfer = afull && (!m_valid || m_ready); on xfer: m_data<=abuf, m_last<=last_r, m_valid<=1, afull<=0, blk_cnt<=blk_cnt+1 (mod 2^64).
REQ-020 xfer and accepted word in same cycle: both occur; new word lands in slot 0 of next block.
REQ-021 m_ready && m_valid && !xfer: m_valid<=0 next cycle; m_data/m_last hold their last value.
REQ-022 m_valid high and m_ready low: m_data, m_last stable, m_valid held.
REQ-023 Latency: word 31 accepted at cycle t with output free -> m_valid high at t+2.
REQ-024 clr: next cycle wcnt=0, afull=0, m_valid=0, m_last=0, blk_cnt=0, ovf=0; clr overrides ld_msg, xfer and m_ready in the same cycle; abuf/m_data contents are don't-care.
REQ-025 m_ready while m_valid low is ignored.

Reset
REQ-026 rst_n low: asynchronously m_valid=0, m_last=0, m_data=0, abuf=0, wcnt=0, afull=0, last_r=0, blk_cnt=0, ovf=0.
REQ-027 Reset mid-block discards the partial block; first word after release goes to slot 0.

Structure
REQ-028 Shared package groestl_pkg holds WORD_W, BLK_W, WORDS_PER_BLK and WCNT_W (5); the word-to-slot mapping is defined there once.
REQ-029 Single module; no sub-module.

Verification
REQ-030 32 words 0x0000..0x001F, m_ready=1 -> m_valid one cycle at t+2, m_data[511:496]=0x0000, m_data[15:0]=0x001F, blk_cnt=1.
REQ-031 Two blocks back-to-back, m_ready=0 -> first block held on m_data, second block sets afull; 33rd word 0xBEEF -> ovf=1, abuf unchanged; m_ready=1 -> both blocks delivered in order, blk_cnt=2.
REQ-032 Word 31 with last_in=1 -> m_last=1 with that block; next block with last_in=0 -> m_last=0.
REQ-033 Word 0xA5A5 arriving with afull=1 in the same cycle m_ready=1 -> xfer occurs, 0xA5A5 lands in bits [511:496] of the next block, ovf stays 0.
REQ-034 rst_n pulsed low after 10 words -> all outputs 0; next 32 words form a clean block with blk_cnt=1.
REQ-035 clr asserted together with m_ready and ld_msg -> m_valid=0, blk_cnt=0, ovf=0, wcnt=0 next cycle; the word presented with clr is not accepted.
